// File: rtl/pe_pkg.sv
// Shared types and fixed-point saturation helpers for the reconfigurable Horner PE.
package pe_pkg;

    localparam int INT_BW_DEF = 5;
    localparam int FRA_BW_DEF = 10;
    localparam int MUL_BW_DEF = 1 + INT_BW_DEF + FRA_BW_DEF;
    localparam int ACC_BW_DEF = 32;

    typedef enum logic [1:0] {
        MODE_GEMM = 2'b00,
        MODE_DIV  = 2'b01,
        MODE_EXP  = 2'b10,
        MODE_LOG  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Accumulator format (Q.2F) to operand format (Q.F), clamping to the operand range.
    function automatic logic signed [63:0] sat_q(input logic signed [63:0] v,
                                                 input int int_bw, input int fra_bw,
                                                 output logic clip);
        logic signed [63:0] hi, lo;
        hi   = (64'sd1 <<< (int_bw + 2 * fra_bw)) - 64'sd1;
        lo   = -(64'sd1 <<< (int_bw + 2 * fra_bw));
        clip = 1'b1;
        if (v > hi)
            sat_q = (64'sd1 <<< (int_bw + fra_bw)) - 64'sd1;
        else if (v < lo)
            sat_q = -(64'sd1 <<< (int_bw + fra_bw));
        else begin
            clip  = 1'b0;
            sat_q = v >>> fra_bw;
        end
    endfunction

    function automatic logic signed [63:0] sat_acc(input logic signed [63:0] v,
                                                   input int acc_bw, output logic clip);
        logic signed [63:0] hi, lo;
        hi   = (64'sd1 <<< (acc_bw - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (acc_bw - 1));
        clip = 1'b1;
        if (v > hi)
            sat_acc = hi;
        else if (v < lo)
            sat_acc = lo;
        else begin
            clip    = 1'b0;
            sat_acc = v;
        end
    endfunction

endpackage

// File: rtl/horner_fsm.sv
// Iterative Horner evaluator: one coefficient per accepted beat, acc = acc*x + c.
module horner_fsm
    import pe_pkg::*;
#(
    parameter int INT_BW = INT_BW_DEF,
    parameter int FRA_BW = FRA_BW_DEF,
    parameter int MUL_BW = MUL_BW_DEF,
    parameter int ACC_BW = ACC_BW_DEF,
    parameter int ORDER  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [ACC_BW-1:0] mac_i,
    input  logic [ACC_BW:0]   sum_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [MUL_BW-1:0] mul_a_o,
    output logic [MUL_BW-1:0] xq_o,
    output logic [ACC_BW-1:0] acc_o,
    output logic              sat_flag_o
);

    localparam int CNT_W = (ORDER < 1) ? 1 : $clog2(ORDER + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_BW-1:0] acc_q, acc_d;
    logic [MUL_BW-1:0] xq_q, xq_d;
    logic              satf_q, satf_d;
    logic              xclip, aclip, mclip;

    // Multiplier operand derived from the running accumulator
    always_comb begin
        mclip   = 1'b0;
        mul_a_o = MUL_BW'(sat_q(64'($signed(acc_q)), INT_BW, FRA_BW, mclip));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        xq_d    = xq_q;
        satf_d  = satf_q;
        xclip   = 1'b0;
        aclip   = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                xq_d    = MUL_BW'(sat_q(64'($signed(mac_i)), INT_BW, FRA_BW, xclip));
                acc_d   = '0;
                cnt_d   = '0;
                satf_d  = xclip;
                state_d = S_ITER;
            end
            S_ITER: if (in_valid_i) begin
                acc_d  = ACC_BW'(sat_acc(64'($signed(sum_i)), ACC_BW, aclip));
                cnt_d  = cnt_q + CNT_W'(1);
                satf_d = satf_q | aclip | mclip;
                if (cnt_q == CNT_W'(ORDER))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            xq_q    <= '0;
            satf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            xq_q    <= xq_d;
            satf_q  <= satf_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign xq_o       = xq_q;
    assign acc_o      = acc_q;
    assign sat_flag_o = satf_q;

endmodule

// File: rtl/pe_r_horner.sv
// Reconfigurable PE: systolic GEMM MAC or Horner-polynomial unary evaluation on one multiplier.
module pe_r_horner
    import pe_pkg::*;
#(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 10,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int ORDER  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        gemm_uno,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_BW-1:0] mac_i,
    input  logic [MUL_BW-1:0] x_i,
    input  logic [MUL_BW-1:0] wc_i,
    input  logic [ACC_BW-1:0] o_i,
    output logic [ACC_BW-1:0] mac_o,
    output logic [ACC_BW-1:0] o_o,
    output logic [MUL_BW-1:0] wc_o,
    output logic              out_valid,
    output logic              busy,
    output logic              sat_flag
);

    logic signed [MUL_BW-1:0]   wreg_q, ireg_q, op_a, op_b, mul_a, xq;
    logic signed [2*MUL_BW-1:0] prod;
    logic signed [ACC_BW:0]     add_x, sum;
    logic [ACC_BW-1:0]          oreg_q, acc;
    logic                       ov_q, fsm_busy, fsm_done, uno_start, gemm_acc;

    // Mode only gates the start; the polynomial itself comes from the streamed coefficients
    assign uno_start = start & (mode_e'(gemm_uno) != MODE_GEMM) & ~fsm_busy;
    assign in_ready  = fsm_busy ? ~fsm_done : ~uno_start;
    assign gemm_acc  = in_valid & ~fsm_busy & ~uno_start;

    assign op_a  = fsm_busy ? mul_a : wreg_q;
    assign op_b  = fsm_busy ? xq : ireg_q;
    assign prod  = (2*MUL_BW)'(op_a) * (2*MUL_BW)'(op_b);
    // One guard bit so the unary path can detect accumulator overflow
    assign add_x = fsm_busy ? ((ACC_BW+1)'($signed(wc_i)) <<< FRA_BW)
                            : (ACC_BW+1)'($signed(o_i));
    assign sum   = (ACC_BW+1)'(prod) + add_x;

    horner_fsm #(
        .INT_BW(INT_BW), .FRA_BW(FRA_BW), .MUL_BW(MUL_BW),
        .ACC_BW(ACC_BW), .ORDER(ORDER)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (uno_start),
        .in_valid_i (in_valid),
        .mac_i      (mac_i),
        .sum_i      (sum),
        .busy_o     (fsm_busy),
        .done_o     (fsm_done),
        .mul_a_o    (mul_a),
        .xq_o       (xq),
        .acc_o      (acc),
        .sat_flag_o (sat_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wreg_q <= '0;
            ireg_q <= '0;
            oreg_q <= '0;
            ov_q   <= 1'b0;
        end else begin
            ov_q <= 1'b0;
            if (gemm_acc) begin
                wreg_q <= wc_i;
                ireg_q <= x_i;
                oreg_q <= sum[ACC_BW-1:0];
                ov_q   <= 1'b1;
            end else if (fsm_done) begin
                oreg_q <= acc;
                ov_q   <= 1'b1;
            end
        end
    end

    assign mac_o     = oreg_q;
    assign o_o       = oreg_q;
    assign wc_o      = wreg_q;
    assign out_valid = ov_q;
    assign busy      = fsm_busy;

endmodule

// File: tb/tb_pe_r_horner.sv
// Scoreboard bench for pe_r_horner: directed plan cases plus randomized GEMM/unary traffic.
module tb_pe_r_horner;

    localparam int     ORDER = 2;
    localparam longint MASK  = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  gemm_uno = 2'b00;
    logic        start = 1'b0, in_valid = 1'b0;
    logic        in_ready, out_valid, busy, sat_flag;
    logic [31:0] mac_i = '0, o_i = '0, mac_o, o_o;
    logic [15:0] x_i = '0, wc_i = '0, wc_o;

    always #5 clk = ~clk;

    pe_r_horner #(.INT_BW(5), .FRA_BW(10), .MUL_BW(16), .ACC_BW(32), .ORDER(ORDER)) dut (
        .clk(clk), .rst_n(rst_n), .gemm_uno(gemm_uno), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .mac_i(mac_i), .x_i(x_i), .wc_i(wc_i), .o_i(o_i),
        .mac_o(mac_o), .o_o(o_o), .wc_o(wc_o), .out_valid(out_valid), .busy(busy),
        .sat_flag(sat_flag)
    );

    typedef struct {
        longint val;
        bit     chk_sat;
        bit     sat;
    } exp_t;

    exp_t   sb[$];
    longint cfq[$];
    int     stq[$];
    int     n_cmp = 0, n_bad = 0;
    longint m_w = 0, m_x = 0;

    task automatic chk(input string nm, input logic [63:0] act, input longint exp);
        n_cmp++;
        if (act !== 64'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Reference arithmetic straight from the number formats: Q5.10 operands, Q.20 accumulator
    function automatic longint m_satq(input longint v, output bit c);
        longint lim;
        lim = 64'sd1 <<< 25;
        c = 1'b1;
        if (v > lim - 1) return 32767;
        if (v < -lim)    return -32768;
        c = 1'b0;
        return v >>> 10;
    endfunction

    function automatic longint m_sat32(input longint v, output bit c);
        c = 1'b1;
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        c = 1'b0;
        return v;
    endfunction

    function automatic longint m_horner(input longint mac, output bit sat, output bit xs);
        bit c;
        longint x, a, s;
        x = m_satq(mac, c);
        xs = c;
        sat = c;
        a = 0;
        foreach (cfq[i]) begin
            s = m_satq(a, c);
            sat |= c;
            a = m_sat32(s * x + cfq[i] * 1024, c);
            sat |= c;
        end
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input longint v, input bit cs, input bit s);
        exp_t e;
        e.val = v & MASK;
        e.chk_sat = cs;
        e.sat = s;
        sb.push_back(e);
    endtask

    task automatic chk_reset();
        chk("rst_o_o", o_o, 0);
        chk("rst_mac_o", mac_o, 0);
        chk("rst_ctl{wc_o,ov,busy,rdy,sat}", {wc_o, out_valid, busy, in_ready, sat_flag}, 2);
    endtask

    task automatic gemm_beat(input logic signed [15:0] wc, input logic signed [15:0] x,
                             input logic [31:0] o);
        start = 1'b0; gemm_uno = 2'b00; in_valid = 1'b1;
        wc_i = wc; x_i = x; o_i = o;
        push(m_w * m_x + longint'(o), 1'b0, 1'b0);
        m_w = longint'(wc);
        m_x = longint'(x);
        tick();
        in_valid = 1'b0;
    endtask

    // Start cycle carries a stray GEMM beat that must be refused
    task automatic unary(input logic [1:0] mode, input logic [31:0] mac, input longint ev,
                         input bit es, input bit xs);
        start = 1'b1; gemm_uno = mode; mac_i = mac;
        in_valid = 1'b1; wc_i = 16'h7777; x_i = 16'h1111; o_i = '0;
        #1 chk("in_ready_at_start", in_ready, 0);
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("sat_after_start", sat_flag, longint'(xs));
        for (int i = 0; i < cfq.size(); i++) begin
            for (int s = 0; s < stq[i]; s++) begin
                in_valid = 1'b0; start = 1'b1;
                gemm_uno = s[0] ? 2'b01 : 2'b00;
                tick();
            end
            start = 1'b0; in_valid = 1'b1; wc_i = 16'(cfq[i]);
            tick();
        end
        in_valid = 1'b0; gemm_uno = 2'b00;
        push(ev, 1'b1, es);
        #1;
        chk("in_ready_done", in_ready, 0);
        chk("busy_done", busy, 1);
        tick();
        chk("busy_idle", busy, 0);
        tick();
        chk("out_valid_pulse", out_valid, 0);
        chk("result_hold", o_o, ev & MASK);
    endtask

    task automatic set_plan(input longint c0, input longint c1, input longint c2,
                            input int s0, input int s1, input int s2);
        cfq.delete(); stq.delete();
        cfq.push_back(c0); cfq.push_back(c1); cfq.push_back(c2);
        stq.push_back(s0); stq.push_back(s1); stq.push_back(s2);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) chk("unexpected_out_valid", out_valid, 0);
            else begin
                e = sb.pop_front();
                chk("result_o_o", o_o, e.val);
                chk("result_mac_o", mac_o, e.val);
                if (e.chk_sat) chk("result_sat_flag", sat_flag, longint'(e.sat));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        longint ev, mac_l;
        bit es, xs;
        #2 chk_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        gemm_beat(16'sd2, 16'sd3, 32'd0);
        gemm_beat(16'sd2, 16'sd3, 32'd5);
        tick();
        chk("gemm_idle_out_valid", out_valid, 0);
        chk("gemm_o_o_hold", o_o, 11);
        chk("gemm_wc_o", wc_o, 2);

        set_plan(1024, 2048, 3072, 0, 0, 0);
        unary(2'b10, 32'h0010_0000, 6291456, 1'b0, 1'b0);
        set_plan(1024, 2048, 3072, 0, 2, 0);
        unary(2'b01, 32'h0010_0000, 6291456, 1'b0, 1'b0);

        set_plan(1024, 0, 0, 0, 0, 0);
        ev = m_horner(longint'(40) <<< 20, es, xs);
        unary(2'b11, 32'(40 << 20), ev, es, 1'b1);
        set_plan(1024, 2048, 3072, 0, 0, 0);
        unary(2'b10, 32'h0010_0000, 6291456, 1'b0, 1'b0);

        // Abort mid-ITER with the saturation flag up
        start = 1'b1; gemm_uno = 2'b10; mac_i = 32'(40 << 20);
        tick();
        start = 1'b0;
        chk("abort_sat_set", sat_flag, 1);
        in_valid = 1'b1; wc_i = 16'd1024;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset();
        m_w = 0; m_x = 0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        set_plan(1024, 2048, 3072, 0, 0, 0);
        unary(2'b10, 32'h0010_0000, 6291456, 1'b0, 1'b0);

        gemm_beat(16'sd5, -16'sd7, 32'd100);
        gemm_beat(16'sd1, 16'sd1, 32'd0);

        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
                    gemm_beat(16'($urandom), 16'($urandom), $urandom);
                    if ($urandom_range(0, 2) == 0) tick();
                end
                tick();
            end else begin
                cfq.delete(); stq.delete();
                for (int k = 0; k <= ORDER; k++) begin
                    cfq.push_back(longint'($urandom_range(0, 8191)) - 4096);
                    stq.push_back(int'($urandom_range(0, 2)));
                end
                mac_l = longint'($urandom_range(0, 1 << 27)) - (longint'(1) <<< 26);
                ev = m_horner(mac_l, es, xs);
                unary(2'(int'($urandom_range(1, 3))), mac_l[31:0], ev, es, xs);
            end
        end

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
